vme_regbank: RTL

Parametrised VME-side register bank: NRW read/write control registers, NRO read-only status registers, and two constant identification words (map version, interface code). It sits between the VME slave core (Clk domain, word-addressed VMEAddr) and user logic. Write path has a one-stage input pipeline; read path has a one-stage output pipeline. Each control register also drives a per-register write strobe.

---
 rtl/vme_regbank.sv | 110 +++++++++++
 1 files changed

// File: rtl/vme_regbank.sv
// VME-side register bank: NRW control registers, NRO status words, map version and interface code.
// Optional macro VME_REGBANK_ERR_EN: unmapped accesses answer with Error instead of Done.
module vme_regbank #(
  parameter int          NRW     = 4,
  parameter int          NRO     = 2,
  parameter int          AW      = 18,
  parameter logic [31:0] RST_VAL = 32'h0,
  parameter logic [31:0] MAPVER  = 32'h0001_0203,
  parameter logic [31:0] ICODE   = 32'h0000_0011
) (
  input  logic                               Clk,
  input  logic                               Rst,
  input  logic [AW+1:2]                      VMEAddr,
  input  logic [31:0]                        VMEWrData,
  input  logic                               VMERdMem,
  input  logic                               VMEWrMem,
  output logic [31:0]                        VMERdData,
  output logic                               VMERdDone,
  output logic                               VMEWrDone,
  output logic                               VMERdError,
  output logic                               VMEWrError,
  output logic [32*NRW-1:0]                  ctrl_o,
  output logic [NRW-1:0]                     ctrl_wstb_o,
  input  logic [32*((NRO > 0) ? NRO : 1)-1:0] stat_i
);

  localparam logic [AW-1:0] LP_MAPVER_ADR = AW'(NRW + NRO);
  localparam logic [AW-1:0] LP_ICODE_ADR  = AW'(NRW + NRO + 1);

  logic [31:0]   r_ctrl [NRW];
  logic [NRW-1:0] r_wstb;
  logic          r_wr_req_d0;
  logic [AW-1:0] r_wr_adr_d0;
  logic [31:0]   r_wr_dat_d0;
  logic [31:0]   r_rd_data;
  logic          r_rd_done;
  logic          r_rd_err;
  logic [31:0]   w_rd_data;
  logic          w_rd_ack;
  logic          w_rd_nak;
  logic          w_wr_ack;
  logic          w_wr_nak;

  // Read mux on the live address; anything unmapped falls through as zero.
  always_comb begin
    w_rd_data = '0;
    for (int k = 0; k < NRW; k++) begin
      if (VMEAddr == AW'(k)) w_rd_data = r_ctrl[k];
    end
    for (int j = 0; j < NRO; j++) begin
      if (VMEAddr == AW'(NRW + j)) w_rd_data = stat_i[32*j +: 32];
    end
    if (VMEAddr == LP_MAPVER_ADR) w_rd_data = MAPVER;
    if (VMEAddr == LP_ICODE_ADR)  w_rd_data = ICODE;
  end

`ifdef VME_REGBANK_ERR_EN
  logic w_rd_mapped;
  logic w_wr_mapped;
  // The map is contiguous from word 0 up to the interface code word.
  assign w_rd_mapped = (VMEAddr <= LP_ICODE_ADR);
  assign w_wr_mapped = (r_wr_adr_d0 <= LP_ICODE_ADR);
  assign w_rd_ack    = VMERdMem & w_rd_mapped;
  assign w_rd_nak    = VMERdMem & ~w_rd_mapped;
  assign w_wr_ack    = r_wr_req_d0 & w_wr_mapped;
  assign w_wr_nak    = r_wr_req_d0 & ~w_wr_mapped;
`else
  assign w_rd_ack    = VMERdMem;
  assign w_rd_nak    = 1'b0;
  assign w_wr_ack    = r_wr_req_d0;
  assign w_wr_nak    = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_wr_req_d0 <= 1'b0;
      r_wr_adr_d0 <= '0;
      r_wr_dat_d0 <= '0;
      r_rd_data   <= '0;
      r_rd_done   <= 1'b0;
      r_rd_err    <= 1'b0;
      r_wstb      <= '0;
      for (int k = 0; k < NRW; k++) r_ctrl[k] <= RST_VAL;
    end else begin
      r_wr_req_d0 <= VMEWrMem;
      r_wr_adr_d0 <= VMEAddr;
      r_wr_dat_d0 <= VMEWrData;
      r_rd_done   <= w_rd_ack;
      r_rd_err    <= w_rd_nak;
      if (VMERdMem) r_rd_data <= w_rd_data;
      for (int k = 0; k < NRW; k++) begin
        r_wstb[k] <= r_wr_req_d0 && (r_wr_adr_d0 == AW'(k));
        if (r_wr_req_d0 && (r_wr_adr_d0 == AW'(k))) r_ctrl[k] <= r_wr_dat_d0;
      end
    end
  end

  for (genvar gi = 0; gi < NRW; gi++) begin : g_ctrl_out
    assign ctrl_o[32*gi +: 32] = r_ctrl[gi];
  end

  // Write ack is combinational from the pipeline stage; suppressed while Rst drops the request.
  assign VMEWrDone   = w_wr_ack & ~Rst;
  assign VMEWrError  = w_wr_nak & ~Rst;
  assign VMERdData   = r_rd_data;
  assign VMERdDone   = r_rd_done;
  assign VMERdError  = r_rd_err;
  assign ctrl_wstb_o = r_wstb;

endmodule
